// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arithmetic ops, iterative shift-add MUL and,
// when SEQ_ALU_DIV_EN is defined, a restoring DIVU (otherwise opcode 1001 is undefined).
module seq_alu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    input  logic [3:0]            ALUControl,
    input  logic                  Start,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic [DATA_WIDTH-1:0] HiResult,
    output logic                  Zero,
    output logic                  Overflow
);

    localparam int               CNT_W     = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SUB  = 4'b0100,
        OP_MUL  = 4'b0101,
        OP_SLT  = 4'b0110,
        OP_SLTU = 4'b0111,
        OP_NOR  = 4'b1000,
        OP_DIVU = 4'b1001
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   opnd_q, opnd_d;      // multiplicand or divisor
    logic [DATA_WIDTH-1:0]   acc_hi_q, acc_hi_d;  // partial product high / remainder
    logic [DATA_WIDTH-1:0]   acc_lo_q, acc_lo_d;  // multiplier / dividend-then-quotient
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic [DATA_WIDTH-1:0]   hi_q, hi_d;
    logic                    ovf_q, ovf_d;
    logic                    done_q, done_d;

    logic [DATA_WIDTH-1:0]   sum, diff, single_res;
    logic                    add_ovf, sub_ovf, single_ovf;
    logic [DATA_WIDTH:0]     mul_sum;
    logic [DATA_WIDTH-1:0]   mul_hi_nxt, mul_lo_nxt;

    assign sum     = SrcA + SrcB;
    assign diff    = SrcA - SrcB;
    assign add_ovf = (SrcA[DATA_WIDTH-1] == SrcB[DATA_WIDTH-1]) && (sum[DATA_WIDTH-1] != SrcA[DATA_WIDTH-1]);
    assign sub_ovf = (SrcA[DATA_WIDTH-1] != SrcB[DATA_WIDTH-1]) && (diff[DATA_WIDTH-1] != SrcA[DATA_WIDTH-1]);

    always_comb begin
        single_res = '0;
        single_ovf = 1'b0;
        case (ALUControl)
            OP_AND:  single_res = SrcA & SrcB;
            OP_OR:   single_res = SrcA | SrcB;
            OP_ADD:  begin single_res = sum;  single_ovf = add_ovf; end
            OP_XOR:  single_res = SrcA ^ SrcB;
            OP_SUB:  begin single_res = diff; single_ovf = sub_ovf; end
            OP_SLT:  single_res = {{(DATA_WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
            OP_SLTU: single_res = {{(DATA_WIDTH-1){1'b0}}, SrcA < SrcB};
            OP_NOR:  single_res = ~(SrcA | SrcB);
            default: ;
        endcase
    end

    // One shift-add step: conditionally add the multiplicand to the high half, then shift right.
    assign mul_sum    = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opnd_q : {DATA_WIDTH{1'b0}})};
    assign mul_hi_nxt = mul_sum[DATA_WIDTH:1];
    assign mul_lo_nxt = {mul_sum[0], acc_lo_q[DATA_WIDTH-1:1]};

`ifdef SEQ_ALU_DIV_EN
    logic [DATA_WIDTH:0]   div_shift;
    logic                  div_ge;
    logic [DATA_WIDTH-1:0] div_rem_nxt, div_quo_nxt;

    // Restoring step; a zero divisor always "fits", yielding all-ones quotient and remainder = SrcA.
    assign div_shift   = {acc_hi_q, acc_lo_q[DATA_WIDTH-1]};
    assign div_ge      = div_shift >= {1'b0, opnd_q};
    assign div_rem_nxt = div_ge ? (div_shift[DATA_WIDTH-1:0] - opnd_q) : div_shift[DATA_WIDTH-1:0];
    assign div_quo_nxt = {acc_lo_q[DATA_WIDTH-2:0], div_ge};
`endif

    always_comb begin
        // NOTE: every *_d starts from its hold value so no path through this block infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        opnd_d   = opnd_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        result_d = result_q;
        hi_d     = hi_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    case (ALUControl)
                        OP_MUL: begin
                            state_d  = MUL;
                            cnt_d    = '0;
                            opnd_d   = SrcA;
                            acc_hi_d = '0;
                            acc_lo_d = SrcB;
                        end
`ifdef SEQ_ALU_DIV_EN
                        OP_DIVU: begin
                            state_d  = DIV;
                            cnt_d    = '0;
                            opnd_d   = SrcB;
                            acc_hi_d = '0;
                            acc_lo_d = SrcA;
                        end
`endif
                        default: begin
                            result_d = single_res;
                            hi_d     = '0;
                            ovf_d    = single_ovf;
                            done_d   = 1'b1;
                        end
                    endcase
                end
            end
            MUL: begin
                acc_hi_d = mul_hi_nxt;
                acc_lo_d = mul_lo_nxt;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    result_d = mul_lo_nxt;
                    hi_d     = mul_hi_nxt;
                    ovf_d    = 1'b0;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end
            end
`ifdef SEQ_ALU_DIV_EN
            DIV: begin
                acc_hi_d = div_rem_nxt;
                acc_lo_d = div_quo_nxt;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    result_d = div_quo_nxt;
                    hi_d     = div_rem_nxt;
                    ovf_d    = 1'b0;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            // NOTE: the datapath registers are reset as well, so nothing downstream ever sees X.
            state_q  <= IDLE;
            cnt_q    <= '0;
            opnd_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            result_q <= '0;
            hi_q     <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opnd_q   <= opnd_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign Busy      = (state_q != IDLE);
    assign Done      = done_q;
    assign ALUResult = result_q;
    assign HiResult  = hi_q;
    assign Overflow  = ovf_q;
    assign Zero      = (result_q == '0);

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: transaction-level reference model compared every cycle,
// directed corner cases with literal expectations, then randomized traffic.
module tb_seq_alu;

    localparam int W = 32;
    localparam longint S_MAX = (longint'(1) <<< (W - 1)) - 1;
    localparam longint S_MIN = -(longint'(1) <<< (W - 1));

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         ovf;
        logic         multi;
    } exp_t;

    logic         clk, rst_n, start;
    logic [3:0]   alu_ctl;
    logic [W-1:0] src_a, src_b;
    logic         busy, done, zero, ovf;
    logic [W-1:0] alu_res, hi_res;

    int  n_total = 0;
    int  n_pass  = 0;
    bit  chk_en  = 1'b0;

    int           m_cnt;
    logic         m_done, m_ovf;
    logic [W-1:0] m_res, m_hi, p_res, p_hi;
    exp_t         c_exp;

    seq_alu #(.DATA_WIDTH(W)) dut (
        .CLK        (clk),
        .RST        (rst_n),
        .SrcA       (src_a),
        .SrcB       (src_b),
        .ALUControl (alu_ctl),
        .Start      (start),
        .Busy       (busy),
        .Done       (done),
        .ALUResult  (alu_res),
        .HiResult   (hi_res),
        .Zero       (zero),
        .Overflow   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Expected outcome of one request, straight from the operation definitions.
    function automatic exp_t compute(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t           e;
        longint         sa, sb, s;
        logic [2*W-1:0] p;
        e  = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (op)
            4'd0: e.res = a & b;
            4'd1: e.res = a | b;
            4'd2: begin e.res = a + b; s = sa + sb; e.ovf = (s > S_MAX) || (s < S_MIN); end
            4'd3: e.res = a ^ b;
            4'd4: begin e.res = a - b; s = sa - sb; e.ovf = (s > S_MAX) || (s < S_MIN); end
            4'd5: begin e.multi = 1'b1; e.res = p[W-1:0]; e.hi = p[2*W-1:W]; end
            4'd6: e.res = {{(W-1){1'b0}}, sa < sb};
            4'd7: e.res = {{(W-1){1'b0}}, a < b};
            4'd8: e.res = ~(a | b);
`ifdef SEQ_ALU_DIV_EN
            4'd9: begin
                e.multi = 1'b1;
                if (b == '0) begin e.res = '1; e.hi = a; end
                else begin e.res = a / b; e.hi = a % b; end
            end
`endif
            default: ;
        endcase
        return e;
    endfunction

    assign c_exp = compute(alu_ctl, src_a, src_b);

    // Reference model: a request either completes at its Start edge or W edges later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_res  <= '0;
            m_hi   <= '0;
            m_ovf  <= 1'b0;
        end else if (m_cnt > 0) begin
            m_cnt  <= m_cnt - 1;
            m_done <= (m_cnt == 1);
            if (m_cnt == 1) begin
                m_res <= p_res;
                m_hi  <= p_hi;
                m_ovf <= 1'b0;
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                if (c_exp.multi) begin
                    m_cnt <= W;
                    p_res <= c_exp.res;
                    p_hi  <= c_exp.hi;
                end else begin
                    m_res  <= c_exp.res;
                    m_hi   <= c_exp.hi;
                    m_ovf  <= c_exp.ovf;
                    m_done <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",     64'(busy),    64'(m_cnt > 0));
            check("done",     64'(done),    64'(m_done));
            check("result",   64'(alu_res), 64'(m_res));
            check("hi",       64'(hi_res),  64'(m_hi));
            check("overflow", 64'(ovf),     64'(m_ovf));
            check("zero",     64'(zero),    64'(m_res == '0));
        end
    end

    // Issue one request from an idle DUT; return cycles until Done and number of Busy cycles.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int busy_n);
        start   = 1'b1;
        alu_ctl = op;
        src_a   = a;
        src_b   = b;
        @(negedge clk);
        start  = 1'b0;
        lat    = 1;
        busy_n = 0;
        while (!done && lat < 100) begin
            if (busy) busy_n++;
            @(negedge clk);
            lat++;
        end
        if (!done) check("done_timeout", 64'(0), 64'(1));
    endtask

    function automatic logic [W-1:0] pick();
        if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 4))
                0:       return '0;
                1:       return 32'h0000_0001;
                2:       return 32'h7FFF_FFFF;
                3:       return 32'h8000_0000;
                default: return 32'hFFFF_FFFF;
            endcase
        end
        return $urandom;
    endfunction

    initial begin
        exp_t e;
        int   lat, bsy, done_cnt;

        rst_n   = 1'b1;
        start   = 1'b0;
        alu_ctl = '0;
        src_a   = '0;
        src_b   = '0;

        e = compute(4'd2, 32'h7FFF_FFFF, 32'h1);
        check("model_add_res", 64'(e.res), 64'h8000_0000);
        check("model_add_ovf", 64'(e.ovf), 64'(1));
        e = compute(4'd4, 32'h8000_0000, 32'h1);
        check("model_sub_res", 64'(e.res), 64'h7FFF_FFFF);
        check("model_sub_ovf", 64'(e.ovf), 64'(1));
        e = compute(4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("model_mul_hi", 64'(e.hi), 64'hFFFF_FFFE);
        check("model_mul_lo", 64'(e.res), 64'h1);
        e = compute(4'd6, 32'hFFFF_FFFF, 32'h1);
        check("model_slt", 64'(e.res), 64'h1);
`ifdef SEQ_ALU_DIV_EN
        e = compute(4'd9, 32'd100, 32'd7);
        check("model_divu_q", 64'(e.res), 64'd14);
        check("model_divu_r", 64'(e.hi), 64'd2);
`endif

        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_res",  64'(alu_res), 64'(0));
        check("rst_zero", 64'(zero), 64'(1));
        chk_en = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        run_op(4'd2, 32'h7FFF_FFFF, 32'h1, lat, bsy);
        check("add_latency", 64'(lat), 64'(1));
        check("add_busy",    64'(bsy), 64'(0));
        check("add_res",     64'(alu_res), 64'h8000_0000);
        check("add_ovf",     64'(ovf), 64'(1));

        run_op(4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bsy);
        check("mul_busy_cycles", 64'(bsy), 64'(32));
        check("mul_done_cycle",  64'(lat), 64'(33));
        check("mul_lo",          64'(alu_res), 64'h1);
        check("mul_hi",          64'(hi_res), 64'hFFFF_FFFE);

        run_op(4'd6, 32'hFFFF_FFFF, 32'h1, lat, bsy);
        check("slt_res", 64'(alu_res), 64'h1);
        run_op(4'd7, 32'hFFFF_FFFF, 32'h1, lat, bsy);
        check("sltu_res",  64'(alu_res), 64'h0);
        check("sltu_zero", 64'(zero), 64'(1));

`ifdef SEQ_ALU_DIV_EN
        run_op(4'd9, 32'd100, 32'd7, lat, bsy);
        check("divu_q",     64'(alu_res), 64'd14);
        check("divu_r",     64'(hi_res), 64'd2);
        check("divu_cycle", 64'(lat), 64'(33));
        run_op(4'd9, 32'd5, 32'd0, lat, bsy);
        check("div0_q", 64'(alu_res), 64'hFFFF_FFFF);
        check("div0_r", 64'(hi_res), 64'd5);
`else
        run_op(4'd9, 32'd100, 32'd7, lat, bsy);
        check("undef_divu_res", 64'(alu_res), 64'(0));
        check("undef_divu_lat", 64'(lat), 64'(1));
`endif

        run_op(4'd2, 32'd1, 32'd2, lat, bsy);
        check("pre_abort_res", 64'(alu_res), 64'd3);

        // MUL in flight, SUB request at cycle 10 ignored, reset at cycle 20 aborts it.
        start   = 1'b1;
        alu_ctl = 4'd5;
        src_a   = 32'h1234_5678;
        src_b   = 32'h9ABC_DEF0;
        @(negedge clk);
        done_cnt = 0;
        for (int c = 1; c < 20; c++) begin
            if (done) done_cnt++;
            start   = (c == 10);
            alu_ctl = 4'd4;
            @(negedge clk);
        end
        start = 1'b0;
        if (done) done_cnt++;
        #2 rst_n = 1'b0;
        #1;
        check("abort_no_done", 64'(done_cnt), 64'(0));
        check("abort_busy",    64'(busy), 64'(0));
        check("abort_done",    64'(done), 64'(0));
        check("abort_res",     64'(alu_res), 64'(0));
        check("abort_hi",      64'(hi_res), 64'(0));
        check("abort_ovf",     64'(ovf), 64'(0));
        check("abort_zero",    64'(zero), 64'(1));
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        run_op(4'd0, 32'h0000_00F0, 32'h0000_000F, lat, bsy);
        check("post_rst_and_lat",  64'(lat), 64'(1));
        check("post_rst_and_res",  64'(alu_res), 64'(0));
        check("post_rst_and_zero", 64'(zero), 64'(1));

        for (int i = 0; i < 3000; i++) begin
            start   = ($urandom_range(0, 1) == 1);
            alu_ctl = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 15));
            src_a   = pick();
            src_b   = pick();
            @(negedge clk);
        end
        start = 1'b0;
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, operand/result width; legal values are even and 8..64.
REQ-002 The block SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RST, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port SrcA, input, DATA_WIDTH, operand A, sampled only on a Start edge.
REQ-005 The block SHALL have port SrcB, input, DATA_WIDTH, operand B, sampled only on a Start edge.
REQ-006 The block SHALL have port ALUControl, input, 4, operation code, sampled only on a Start edge.
REQ-007 The block SHALL have port Start, input, 1, request; accepted only when Busy=0.
REQ-008 The block SHALL have port Busy, output, 1, high while a multi-cycle operation runs.
REQ-009 The block SHALL have port Done, output, 1, one-cycle pulse when results are valid.
REQ-010 The block SHALL have port ALUResult, output, DATA_WIDTH, registered primary result (low word/quotient).
REQ-011 The block SHALL have port HiResult, output, DATA_WIDTH, registered secondary result (high word/remainder), otherwise 0.
REQ-012 The block SHALL have port Zero, output, 1, high when registered ALUResult is all zeros.
REQ-013 The block SHALL have port Overflow, output, 1, registered signed overflow for ADD/SUB, 0 for all other operations.

Function
REQ-014 The block SHALL decode ALUControl: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SUB, 0101 MUL (unsigned, 2*DATA_WIDTH product), 0110 SLT (signed), 0111 SLTU, 1000 NOR, 1001 DIVU; any other code gives ALUResult=0, HiResult=0, 1-cycle latency.
REQ-015 The block SHALL use FSM states IDLE, MUL, DIV; Start in IDLE with a single-cycle opcode stays in IDLE; MUL/DIV enter the matching state.
REQ-016 Single-cycle ops SHALL register results on the Start edge, with Done=1 in the following cycle (latency 1) and Busy staying 0.
REQ-017 MUL SHALL be an iterative shift-add, one bit per cycle; Busy=1 from the cycle after Start; results register and Done pulses after exactly DATA_WIDTH cycles, then the FSM returns to IDLE.
REQ-018 DIVU SHALL be a restoring divider, one bit per cycle, with the same DATA_WIDTH latency and Busy/Done timing as MUL.
REQ-019 DIVU with SrcB=0 SHALL give ALUResult all-ones, HiResult=SrcA, Done at normal latency, and no hang.
REQ-020 Start while Busy=1 SHALL be ignored, with no effect on the operation in flight.
REQ-021 Start in the same cycle as Done SHALL be accepted, giving back-to-back operations.
REQ-022 Outputs SHALL hold their last values until the next Done; SLT/SLTU results are 0 or 1, zero-extended.
REQ-023 ADD/SUB SHALL wrap modulo 2^DATA_WIDTH; Overflow=1 when operand signs imply a signed overflow.

Reset
REQ-024 RST low SHALL immediately force the FSM to IDLE, iteration counter to 0, Busy=0, Done=0, ALUResult=0, HiResult=0, Overflow=0, Zero=1.
REQ-025 Reset during MUL/DIV SHALL abort the operation without a Done; the first Start after RST deasserts is accepted normally.

Configuration
REQ-026 With macro SEQ_ALU_DIV_EN defined, DIVU and the DIV state SHALL be built as specified.
REQ-027 Without SEQ_ALU_DIV_EN, opcode 1001 SHALL be treated as an undefined opcode (result 0, latency 1), and no divider logic is synthesised.

Verification (DATA_WIDTH=32)
REQ-028 ADD 0x7FFFFFFF+1 -> ALUResult=0x80000000, Overflow=1, Done one cycle after Start, Busy never high.
REQ-029 MUL 0xFFFFFFFF*0xFFFFFFFF -> HiResult=0xFFFFFFFE, ALUResult=0x00000001, Done exactly 32 cycles after Start, Busy high for 32 cycles.
REQ-030 DIVU 100/7 (macro on) -> ALUResult=14, HiResult=2; DIVU 5/0 -> ALUResult=0xFFFFFFFF, HiResult=5.
REQ-031 SLT 0xFFFFFFFF vs 1 -> 1; SLTU on the same operands -> 0 with Zero=1.
REQ-032 Start MUL, pulse Start with SUB at cycle 10, assert RST at cycle 20 -> SUB ignored, no Done, all outputs at reset values, a following AND 0xF0&0x0F gives 0 with Zero=1.
REQ-033 Macro off, opcode 1001 with 100/7 -> ALUResult=0, Done after 1 cycle.
